// File: rtl/bcd_7seg_pkg.sv
// Shared constants for the BCD-to-7-segment display path.
// Segment vectors are {a,b,c,d,e,f,g} with a in bit 6.
package bcd_7seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to 7-segment pattern; codes 10..15 render as a dash.
module bcd_seg_decode
    import bcd_7seg_pkg::*;
(
    input  logic [3:0]       code,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        if (blank) begin
            seg_c = SEG_BLANK;
        end else begin
            case (code)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed multi-digit 7-segment scanner with per-frame snapshot,
// dead-time between digits and optional leading-zero blanking.
module bcd_7seg_scan
    import bcd_7seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIV            = 50000,
    parameter int unsigned COM_ACTIVE_LOW = 1,
    parameter int unsigned BLANK_LEADING  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [SEG_W-1:0]        Segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{COM_ACTIVE_LOW != 0}};

    scan_state_e            state, state_n;
    logic [PRE_W-1:0]       presc, presc_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [BCD_W-1:0]       snap, snap_n;
    logic [NUM_DIGITS-1:0]  snap_dp, snap_dp_n;

    logic [3:0]             code_n;
    logic                   blank_n;
    logic                   dp_n;
    logic                   fd_n;
    logic [NUM_DIGITS-1:0]  sel_n;
    logic [NUM_DIGITS-1:0]  zero_tail;
    logic [SEG_W-1:0]       seg_n;

    // Next state, prescaler, digit index and snapshot
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        idx_n     = idx;
        snap_n    = snap;
        snap_dp_n = snap_dp;
        case (state)
            IDLE: begin
                presc_n = '0;
                idx_n   = '0;
                if (enable) begin
                    state_n   = SCAN;
                    snap_n    = bcd_in;
                    snap_dp_n = dp_in;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_n = IDLE;
                    presc_n = '0;
                    idx_n   = '0;
                end else if (presc == PRE_LAST) begin
                    presc_n = '0;
                    if (idx == IDX_LAST) begin
                        idx_n     = '0;
                        snap_n    = bcd_in;
                        snap_dp_n = dp_in;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    presc_n = presc + PRE_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the values being loaded so they line up with them
    always_comb begin
        code_n  = 4'd0;
        dp_n    = 1'b0;
        blank_n = 1'b1;
        fd_n    = 1'b0;
        sel_n   = SEL_OFF;

        zero_tail[NUM_DIGITS-1] = (snap_n[BCD_W-1 -: 4] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            zero_tail[k] = zero_tail[k+1] && (snap_n[4*k +: 4] == 4'd0);
        end

        if (state_n == SCAN) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (idx_n == IDX_W'(k)) begin
                    code_n  = snap_n[4*k +: 4];
                    dp_n    = snap_dp_n[k];
                    blank_n = (BLANK_LEADING != 0) && (k != 0) && zero_tail[k];
                    if (presc_n != '0) begin
                        sel_n[k] = ~SEL_OFF[k];
                    end
                end
            end
            fd_n = (presc_n == PRE_LAST) && (idx_n == IDX_LAST);
        end
    end

    bcd_seg_decode u_decode (
        .code  (code_n),
        .blank (blank_n),
        .seg_c (seg_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= '0;
            snap       <= '0;
            snap_dp    <= '0;
            Segment    <= SEG_BLANK;
            dp         <= 1'b0;
            digit_sel  <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            idx        <= idx_n;
            snap       <= snap_n;
            snap_dp    <= snap_dp_n;
            Segment    <= seg_n;
            dp         <= dp_n;
            digit_sel  <= sel_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with 4 digits, DIV = 4, active-low commons.
module tb_bcd_7seg_scan;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] SD = 7'b0000001;
    localparam logic [6:0] SB = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [6:0]  Segment;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_7seg_scan #(
        .NUM_DIGITS     (4),
        .DIV            (4),
        .COM_ACTIVE_LOW (1),
        .BLANK_LEADING  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .Segment    (Segment),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_off(input string tag);
        check_val({tag, " sel"}, 32'(digit_sel), 32'h0000000F);
        check_val({tag, " seg"}, 32'(Segment), 32'h0);
        check_val({tag, " dp"}, 32'(dp), 32'h0);
        check_val({tag, " fd"}, 32'(frame_done), 32'h0);
    endtask

    // Checks one full frame starting at the dead cycle of digit 0.
    task automatic run_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dps,
                             input int chg_at, input logic [15:0] chg_bcd);
        logic [6:0] es [4];
        logic [3:0] exp_sel;
        int d;
        int p;
        es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
        for (int c = 0; c < 16; c++) begin
            d = c / 4;
            p = c % 4;
            exp_sel = (p == 0) ? 4'hF : ~(4'b0001 << d);
            check_val($sformatf("%s d%0d p%0d sel", tag, d, p), 32'(digit_sel), 32'(exp_sel));
            check_val($sformatf("%s d%0d p%0d seg", tag, d, p), 32'(Segment), 32'(es[d]));
            check_val($sformatf("%s d%0d p%0d dp", tag, d, p), 32'(dp), 32'(dps[d]));
            check_val($sformatf("%s d%0d p%0d fd", tag, d, p), 32'(frame_done), 32'(c == 15));
            if (c == chg_at) bcd_in = chg_bcd;
            tick();
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        tick();
        tick();
        check_off("reset");
        rst = 1'b0;
        tick();
        tick();
        check_off("idle after reset");

        bcd_in = 16'h1234;
        dp_in  = 4'b0100;
        enable = 1'b1;
        tick();
        run_frame("f1 1234", S4, S3, S2, S1, 4'b0100, -1, 16'h0);
        run_frame("f2 1234 chg", S4, S3, S2, S1, 4'b0100, 5, 16'h5678);
        run_frame("f3 5678", S8, S7, S6, S5, 4'b0100, 0, 16'h0007);
        run_frame("f4 0007", S7, SB, SB, SB, 4'b0100, 0, 16'h0000);
        run_frame("f5 0000", S0, SB, SB, SB, 4'b0100, 0, 16'h00A5);
        run_frame("f6 00A5", S5, SD, SB, SB, 4'b0100, 0, 16'h1234);
        run_frame("f7 1234", S4, S3, S2, S1, 4'b0100, -1, 16'h0);

        // Drop enable in the middle of digit 2
        for (int c = 0; c < 9; c++) tick();
        check_val("pre-disable sel", 32'(digit_sel), 32'h0000000B);
        check_val("pre-disable seg", 32'(Segment), 32'(S2));
        check_val("pre-disable dp", 32'(dp), 32'h1);
        enable = 1'b0;
        tick();
        check_off("disabled");
        for (int c = 0; c < 12; c++) begin
            tick();
            check_off($sformatf("disabled c%0d", c));
        end
        enable = 1'b1;
        tick();
        run_frame("re-enable 1234", S4, S3, S2, S1, 4'b0100, -1, 16'h0);

        // Asynchronous reset in the middle of an active slot
        tick();
        check_val("pre-reset sel", 32'(digit_sel), 32'h0000000E);
        #2 rst = 1'b1;
        #1;
        check_off("async reset");
        enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_off($sformatf("post-reset idle c%0d", c));
        end
        enable = 1'b1;
        tick();
        run_frame("after reset 1234", S4, S3, S2, S1, 4'b0100, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
